dpcm_tx_serializer: RTL and testbench
=====================================

// Module: dpcm_tx_serializer
// PURPOSE
// - Transmit end of the DPCM sample link: turns signed 8-bit samples into a serial bit stream for the receive-side decoder.
// - Per sample: diff = sample - predictor, saturated to signed WIDTH.
// - The diff is shifted out MSB first, and the predictor is updated so it tracks the decoder's reconstruction.
// - Sits between the sample source and the serial channel; feeds the decode/filter chain.
// PARAMETERS
// - WIDTH    8  sample and diff width, two's complement
// - BIT_DIV  1  clock cycles each serial bit is held (>=1)
// PORTS
// - CLK100MHZ     in   1      system clock; all logic on posedge
// - reset         in   1      synchronous, active-high reset
// - start         in   1      enable; low = accept no new samples
// - sample_in     in   WIDTH  signed input sample
// - sample_valid  in   1      sample_in valid this cycle
// - sample_ready  out  1      block can accept a sample this cycle
// - bit_out       out  1      serial diff bit, MSB first
// - bit_valid     out  1      bit_out carries a frame bit
// - frame_start   out  1      high during the first (MSB) bit period of a frame
// - encoded       out  WIDTH  parallel copy of the frame's saturated diff
// - pred_out      out  WIDTH  signed current predictor (reconstructed sample)
// BEHAVIOUR
// - Reset: next edge after reset=1 clears all of the following:
//   - state=IDLE; bit_out, bit_valid, frame_start = 0; encoded=0; pred_out=0; bit and divider counters = 0.
//   - reset has priority over all other inputs, including mid-frame: the frame is dropped with no partial bits.
// - sample_ready = start & (state==IDLE) & ~reset; combinational.
// - Accept: sample_valid & sample_ready at edge N.
//   - d9 = sext(sample_in) - sext(pred), computed 9 bits wide.
//   - diff = clamp(d9, -2^(WIDTH-1), 2^(WIDTH-1)-1).
//   - At the same edge: encoded<=diff; pred<=pred+diff (no overflow possible after clamp); state->SHIFT.
// - SHIFT:
//   - From cycle N+1: bit_out = encoded[WIDTH-1-k] for bit index k = 0..WIDTH-1.
//   - Each bit is held BIT_DIV cycles; bit_valid=1 throughout.
//   - frame_start=1 only for the k=0 bit period.
//   - After the last cycle of bit WIDTH-1: state->IDLE; bit_out, bit_valid = 0; encoded holds its value.
//   - sample_ready rises the cycle after the last bit, so throughput is 1 sample per WIDTH*BIT_DIV+1 cycles.
// - sample_valid while not ready is ignored; there is no buffering and the source must hold the sample.
// - start deasserted mid-frame: the current frame completes normally, then the block stays IDLE.
// - start low in IDLE: outputs stay idle and pred is held.
// - Predictor wrap: never wraps. Saturation makes pred lag the sample by the excess; pred equals the decoder's result.
// - Diff boundaries:
//   - d9 = +255 -> diff 127 (0x7F).
//   - d9 = -255 -> diff -128 (0x80).
//   - d9 = 0 -> frame of all zeros with bit_valid=1.
// - States: IDLE (wait for accept), SHIFT (output bits). No other states; an illegal state -> IDLE.
// TESTING
// - Reset, start=1, no valid -> sample_ready=1; bit_out, bit_valid, frame_start, pred_out all 0.
// - Sample 20 (BIT_DIV=1) from pred 0 -> over 8 cycles bit_out=0,0,0,1,0,1,0,0; frame_start only on cycle 1; encoded=0x14; pred_out=20.
// - Sample 20 again -> 8 zero bits with bit_valid=1; pred_out stays 20; sample_ready=0 for 8 cycles, then 1.
// - Saturation, from pred 0:
//   - Sample 127 -> diff 0x7F, pred 127.
//   - Then sample -128 -> diff 0x80, bits 1,0,0,0,0,0,0,0, pred -1.
// - reset=1 during bit 3 -> next cycle bit_valid=0, pred_out=0, sample_ready=1 after reset drops; no trailing bits.
// - BIT_DIV=4, start dropped during bit 2 -> each bit held 4 cycles; frame completes (32 cycles); sample_valid afterwards ignored; sample_ready stays 0.

Source files
------------

// File: rtl/dpcm_tx_serializer.sv
// DPCM transmit serializer: encodes each signed sample as a saturated difference
// against a predictor and shifts that difference out MSB first.
module dpcm_tx_serializer #(
    parameter int WIDTH   = 8,
    parameter int BIT_DIV = 1
) (
    input  logic             CLK100MHZ,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             frame_start,
    output logic [WIDTH-1:0] encoded,
    output logic [WIDTH-1:0] pred_out
);

    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01
    } state_t;

    // Clamp a WIDTH+1 bit signed difference into the signed WIDTH range.
    function automatic logic [WIDTH-1:0] sat_diff(input logic signed [WIDTH:0] d);
        logic signed [WIDTH:0] d_max;
        logic signed [WIDTH:0] d_min;
        d_max = {2'b00, {(WIDTH-1){1'b1}}};
        d_min = {2'b11, {(WIDTH-1){1'b0}}};
        if (d > d_max) begin
            return d_max[WIDTH-1:0];
        end else if (d < d_min) begin
            return d_min[WIDTH-1:0];
        end else begin
            return d[WIDTH-1:0];
        end
    endfunction

    state_t             state_r;
    logic [BIT_W-1:0]   bit_cnt_r;
    logic [DIV_W-1:0]   div_cnt_r;
    logic [WIDTH-1:0]   shift_r;
    logic [WIDTH-1:0]   encoded_r;
    logic [WIDTH-1:0]   pred_r;
    logic               bit_out_r;
    logic               bit_valid_r;
    logic               frame_start_r;

    logic               accept_s;
    logic signed [WIDTH:0] d9_s;
    logic [WIDTH-1:0]   diff_s;

    assign sample_ready = start & (state_r == ST_IDLE) & ~reset;
    assign accept_s     = sample_valid & sample_ready;

    // Saturated difference between the incoming sample and the predictor.
    always_comb begin
        d9_s   = $signed({sample_in[WIDTH-1], sample_in}) - $signed({pred_r[WIDTH-1], pred_r});
        diff_s = sat_diff(d9_s);
    end

    // Frame state machine, predictor update and serial output registers.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            bit_cnt_r     <= '0;
            div_cnt_r     <= '0;
            shift_r       <= '0;
            encoded_r     <= '0;
            pred_r        <= '0;
            bit_out_r     <= 1'b0;
            bit_valid_r   <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r       <= ST_SHIFT;
                        encoded_r     <= diff_s;
                        pred_r        <= pred_r + diff_s;
                        bit_out_r     <= diff_s[WIDTH-1];
                        shift_r       <= {diff_s[WIDTH-2:0], 1'b0};
                        bit_valid_r   <= 1'b1;
                        frame_start_r <= 1'b1;
                        bit_cnt_r     <= '0;
                        div_cnt_r     <= '0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (div_cnt_r == DIV_LAST) begin
                        div_cnt_r <= '0;
                        if (bit_cnt_r == BIT_LAST) begin
                            // Frame done; encoded keeps the last diff for observation.
                            state_r       <= ST_IDLE;
                            bit_cnt_r     <= '0;
                            bit_out_r     <= 1'b0;
                            bit_valid_r   <= 1'b0;
                            frame_start_r <= 1'b0;
                        end else begin
                            bit_cnt_r     <= bit_cnt_r + 1'b1;
                            bit_out_r     <= shift_r[WIDTH-1];
                            shift_r       <= {shift_r[WIDTH-2:0], 1'b0};
                            frame_start_r <= 1'b0;
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    bit_cnt_r     <= '0;
                    div_cnt_r     <= '0;
                    bit_out_r     <= 1'b0;
                    bit_valid_r   <= 1'b0;
                    frame_start_r <= 1'b0;
                end
            endcase
        end
    end

    assign bit_out     = bit_out_r;
    assign bit_valid   = bit_valid_r;
    assign frame_start = frame_start_r;
    assign encoded     = encoded_r;
    assign pred_out    = pred_r;

endmodule

// File: tb/tb_dpcm_tx_serializer.sv
// Bench for dpcm_tx_serializer: one instance with BIT_DIV=1 and one with BIT_DIV=4,
// checked against an arithmetic model of the predictor and the serial frame.
module tb_dpcm_tx_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_reset, a_start, a_valid;
    logic [7:0] a_sample;
    logic       a_ready, a_bit, a_bv, a_fs;
    logic [7:0] a_enc, a_pred;

    logic       b_reset, b_start, b_valid;
    logic [7:0] b_sample;
    logic       b_ready, b_bit, b_bv, b_fs;
    logic [7:0] b_enc, b_pred;

    int n_cmp = 0;
    int n_err = 0;
    int pred_m [2];

    dpcm_tx_serializer #(.WIDTH(8), .BIT_DIV(1)) u_dut1 (
        .CLK100MHZ(clk), .reset(a_reset), .start(a_start),
        .sample_in(a_sample), .sample_valid(a_valid), .sample_ready(a_ready),
        .bit_out(a_bit), .bit_valid(a_bv), .frame_start(a_fs),
        .encoded(a_enc), .pred_out(a_pred)
    );

    dpcm_tx_serializer #(.WIDTH(8), .BIT_DIV(4)) u_dut4 (
        .CLK100MHZ(clk), .reset(b_reset), .start(b_start),
        .sample_in(b_sample), .sample_valid(b_valid), .sample_ready(b_ready),
        .bit_out(b_bit), .bit_valid(b_bv), .frame_start(b_fs),
        .encoded(b_enc), .pred_out(b_pred)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic o_rdy(input bit sel);  return sel ? b_ready : a_ready; endfunction
    function automatic logic o_bit(input bit sel);  return sel ? b_bit   : a_bit;   endfunction
    function automatic logic o_bv(input bit sel);   return sel ? b_bv    : a_bv;    endfunction
    function automatic logic o_fs(input bit sel);   return sel ? b_fs    : a_fs;    endfunction
    function automatic logic [7:0] o_enc(input bit sel);  return sel ? b_enc  : a_enc;  endfunction
    function automatic logic [7:0] o_pred(input bit sel); return sel ? b_pred : a_pred; endfunction
    function automatic logic o_start(input bit sel); return sel ? b_start : a_start; endfunction

    task automatic set_valid(input bit sel, input logic v, input logic [7:0] s);
        if (sel) begin b_valid = v; b_sample = s; end
        else     begin a_valid = v; a_sample = s; end
    endtask

    task automatic set_start(input bit sel, input logic v);
        if (sel) b_start = v; else a_start = v;
    endtask

    task automatic do_reset(input bit sel);
        int pm;
        @(negedge clk);
        set_valid(sel, 1'b0, 8'h00);
        if (sel) b_reset = 1'b1; else a_reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready_low", 32'(o_rdy(sel)), 32'd0);
        if (sel) b_reset = 1'b0; else a_reset = 1'b0;
        #1;
        pred_m[sel] = 0;
        pm = pred_m[sel];
        chk("rst_ready", 32'(o_rdy(sel)), 32'(o_start(sel)));
        chk("rst_bit_out", 32'(o_bit(sel)), 32'd0);
        chk("rst_bit_valid", 32'(o_bv(sel)), 32'd0);
        chk("rst_frame_start", 32'(o_fs(sel)), 32'd0);
        chk("rst_encoded", 32'(o_enc(sel)), 32'd0);
        chk("rst_pred", 32'(o_pred(sel)), 32'(pm[7:0]));
    endtask

    // Send one sample and check every cycle of the frame; drop_bit >= 0 lowers start there.
    task automatic frame(input bit sel, input int s, input int drop_bit);
        int d, pm, dv;
        bit got;
        logic [7:0] enc;
        logic [7:0] sv;
        dv = sel ? 4 : 1;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (o_rdy(sel)) begin
                got = 1'b1;
                break;
            end
        end
        chk("ready_wait", 32'(got), 32'd1);
        d = s - pred_m[sel];
        if (d > 127) d = 127;
        if (d < -128) d = -128;
        pred_m[sel] = pred_m[sel] + d;
        pm = pred_m[sel];
        enc = d[7:0];
        sv = s[7:0];
        set_valid(sel, 1'b1, sv);
        chk("ready_at_accept", 32'(o_rdy(sel)), 32'd1);
        @(negedge clk);
        set_valid(sel, 1'b0, sv);
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < dv; c++) begin
                chk("bit_valid", 32'(o_bv(sel)), 32'd1);
                chk("bit_out", 32'(o_bit(sel)), 32'(enc[7-k]));
                chk("frame_start", 32'(o_fs(sel)), 32'(k == 0));
                chk("ready_busy", 32'(o_rdy(sel)), 32'd0);
                chk("encoded", 32'(o_enc(sel)), 32'(enc));
                chk("pred", 32'(o_pred(sel)), 32'(pm[7:0]));
                if (k == drop_bit && c == 0) set_start(sel, 1'b0);
                if (!(k == 7 && c == dv - 1)) @(negedge clk);
            end
        end
        @(negedge clk);
        chk("end_bit_valid", 32'(o_bv(sel)), 32'd0);
        chk("end_bit_out", 32'(o_bit(sel)), 32'd0);
        chk("end_frame_start", 32'(o_fs(sel)), 32'd0);
        chk("end_ready", 32'(o_rdy(sel)), 32'(o_start(sel)));
        chk("end_encoded", 32'(o_enc(sel)), 32'(enc));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        int pm;
        a_reset = 1'b1; a_start = 1'b1; a_valid = 1'b0; a_sample = 8'h00;
        b_reset = 1'b1; b_start = 1'b1; b_valid = 1'b0; b_sample = 8'h00;
        pred_m[0] = 0;
        pred_m[1] = 0;

        // Reset state and basic frames at BIT_DIV=1.
        do_reset(1'b0);
        frame(1'b0, 20, -1);
        frame(1'b0, 20, -1);

        // Saturation boundaries.
        do_reset(1'b0);
        frame(1'b0, 127, -1);
        frame(1'b0, -128, -1);
        chk("sat_pred_minus1", 32'(a_pred), 32'hFF);

        // Reset asserted during bit 3 drops the frame.
        @(negedge clk);
        a_valid = 1'b1; a_sample = 8'd50;
        @(negedge clk);
        a_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_bit3_valid", 32'(a_bv), 32'd1);
        a_reset = 1'b1;
        @(negedge clk);
        chk("midrst_bit_valid", 32'(a_bv), 32'd0);
        chk("midrst_pred", 32'(a_pred), 32'd0);
        chk("midrst_ready_low", 32'(a_ready), 32'd0);
        a_reset = 1'b0;
        #1;
        chk("midrst_ready", 32'(a_ready), 32'd1);
        pred_m[0] = 0;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_trail", 32'(a_bv), 32'd0);
        end

        // Random samples against the model.
        for (int i = 0; i < 20; i++) begin
            r = 8'($urandom);
            frame(1'b0, int'($signed(r)), -1);
        end

        // BIT_DIV=4: start dropped during bit 2, frame still completes.
        do_reset(1'b1);
        frame(1'b1, 77, 2);
        pm = pred_m[1];
        b_valid = 1'b1; b_sample = 8'h05;
        repeat (5) begin
            @(negedge clk);
            chk("nostart_bit_valid", 32'(b_bv), 32'd0);
            chk("nostart_ready", 32'(b_ready), 32'd0);
            chk("nostart_pred", 32'(b_pred), 32'(pm[7:0]));
        end
        b_valid = 1'b0;
        b_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            r = 8'($urandom);
            frame(1'b1, int'($signed(r)), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
